// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: WIDTH bits in STAGES chunks of BLOCK-bit groups.
// Define CLA_SUB_EN to add the sub port (x - y via inverted y, carry-in forced to 1).
module cla_pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 4,
  parameter int STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       x,
  input  logic [WIDTH-1:0]       y,
  input  logic                   c0,
`ifdef CLA_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       s,
  output logic                   cout,
  output logic                   ovf,
  output logic [WIDTH/BLOCK-1:0] gc
);
  localparam int CW  = WIDTH / STAGES;
  localparam int GPC = CW / BLOCK;
  localparam int L   = STAGES - 1;

  if (WIDTH % (BLOCK * STAGES) != 0) begin : g_bad
    $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK*STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] yv;
  logic             ci0;
  logic             ovf_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

`ifdef CLA_SUB_EN
  assign yv  = sub ? ~y : y;
  assign ci0 = sub | c0;
`else
  assign yv  = y;
  assign ci0 = c0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // UW: operand bits still waiting for later stages
    localparam int UW = WIDTH - (k + 1) * CW;
    localparam int DW = (k + 1) * CW;
    localparam int GW = (k + 1) * GPC;

    logic [CW-1:0]  a, b, gg, gp, bc, sum;
    logic [GPC-1:0] grp_g, grp_p;
    logic [GPC:0]   gcar;
    logic           rc, ci, v_d, v_q, c_q;
    logic [DW-1:0]  s_d, s_q;
    logic [GW-1:0]  gc_d, gc_q;

    if (k == 0) begin : g_in
      assign a    = x[CW-1:0];
      assign b    = yv[CW-1:0];
      assign ci   = ci0;
      assign v_d  = in_valid;
      assign s_d  = sum;
      assign gc_d = gcar[GPC:1];
    end else begin : g_in
      assign a    = g_st[k-1].g_op.xq[CW-1:0];
      assign b    = g_st[k-1].g_op.yq[CW-1:0];
      assign ci   = g_st[k-1].c_q;
      assign v_d  = g_st[k-1].v_q;
      assign s_d  = {sum, g_st[k-1].s_q};
      assign gc_d = {gcar[GPC:1], g_st[k-1].gc_q};
    end

    if (UW > 0) begin : g_op
      logic [UW-1:0] xq, yq, xd, yd;
      if (k == 0) begin : g_src
        assign xd = x[WIDTH-1:CW];
        assign yd = yv[WIDTH-1:CW];
      end else begin : g_src
        assign xd = g_st[k-1].g_op.xq[UW+CW-1:CW];
        assign yd = g_st[k-1].g_op.yq[UW+CW-1:CW];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          xq <= '0;
          yq <= '0;
        end else if (en) begin
          xq <= xd;
          yq <= yd;
        end
      end
    end

    // group G/P lookahead, then bit carries inside each group
    always_comb begin
      gg      = a & b;
      gp      = a ^ b;
      grp_g   = '0;
      grp_p   = '0;
      bc      = '0;
      gcar    = '0;
      rc      = 1'b0;
      gcar[0] = ci;
      for (int i = 0; i < GPC; i++) begin
        grp_p[i] = 1'b1;
        for (int j = 0; j < BLOCK; j++) begin
          grp_g[i] = gg[i*BLOCK+j] |
                     (gp[i*BLOCK+j] & grp_g[i]);
          grp_p[i] = grp_p[i] & gp[i*BLOCK+j];
        end
        gcar[i+1] = grp_g[i] | (grp_p[i] & gcar[i]);
        rc = gcar[i];
        for (int j = 0; j < BLOCK; j++) begin
          bc[i*BLOCK+j] = rc;
          rc = gg[i*BLOCK+j] | (gp[i*BLOCK+j] & rc);
        end
      end
      sum = gp ^ bc;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        s_q  <= '0;
        gc_q <= '0;
      end else if (en) begin
        v_q  <= v_d;
        c_q  <= gcar[GPC];
        s_q  <= s_d;
        gc_q <= gc_d;
      end
    end
  end

  // overflow = carry into MSB xor carry out of MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= g_st[L].bc[CW-1] ^ g_st[L].gcar[GPC];
    end
  end

  assign s         = g_st[L].s_q;
  assign cout      = g_st[L].c_q;
  assign gc        = g_st[L].gc_q;
  assign out_valid = g_st[L].v_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder at WIDTH=64 BLOCK=4 STAGES=4.
// Driver pushes hand-computed results; monitor pops on each output transfer.
`timescale 1ns/1ps
module tb_cla_pipe_adder;
  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic [15:0] gc;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x = '0;
  logic [63:0] y = '0;
  logic        c0 = 1'b0;
  logic        sub_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] s;
  logic        cout;
  logic        ovf;
  logic [15:0] gc;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  cla_pipe_adder dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
    .c0(c0),
`ifdef CLA_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s(s),
    .cout(cout),
    .ovf(ovf),
    .gc(gc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [79:0] act,
                     input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [63:0] a,
                      input logic [63:0] b,
                      input logic ci,
                      input logic sb,
                      input logic [63:0] es,
                      input logic ec,
                      input logic eo,
                      input logic [15:0] eg,
                      input bit lat);
    exp_t e;
    int n;
    n = 0;
    x = a;
    y = b;
    c0 = ci;
    sub_i = sb;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else begin
      e.s = es;
      e.cout = ec;
      e.ovf = eo;
      e.gc = eg;
      e.acc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stale: got s=%0h want no output", s);
      end else begin
        e = exp_q.pop_front();
        chk("s", s, e.s);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        chk("gc", gc, e.gc);
        if (e.lat) chk("latency", cyc - e.acc, 4);
      end
    end
  end

  initial begin
    logic [9:0]  gc4;
    logic [63:0] snap;
    gc4 = 10'b11_0011_0000;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_gc", gc, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    send(64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 0, 0,
         64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 16'h0000, 1);
    drain();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0,
         64'h0, 1, 0, 16'hFFFF, 1);
    drain();
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0,
         64'h8000_0000_0000_0000, 0, 1, 16'h7FFF, 1);
    drain();
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 0,
         64'h0, 1, 0, 16'hFFFF, 1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0,
         64'h0, 1, 1, 16'h8000, 1);
    send(64'hF, 64'h1, 0, 0, 64'h10, 0, 0, 16'h0001, 1);
    drain();

    for (int i = 0; i < 10; i++) begin
      send(64'(i), 64'(3 * i), 0, 0, 64'(4 * i), 0, 0,
           {15'h0, gc4[i]}, i < 4);
    end
    out_ready = 1'b0;
    #1;
    chk("stall_valid", out_valid, 1);
    snap = s;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", in_ready, 0);
      chk("stall_hold", s, snap);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();

    for (int i = 0; i < 3; i++) begin
      send(64'(100 + i), 64'h1, 0, 0, 64'(101 + i), 0, 0,
           16'h0, 0);
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_s", s, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send(64'h5, 64'h6, 0, 0, 64'hB, 0, 0, 16'h0, 1);
    drain();

`ifdef CLA_SUB_EN
    send(64'h5, 64'h7, 0, 1,
         64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 16'h0000, 1);
    send(64'h7, 64'h5, 1, 1,
         64'h2, 1, 0, 16'hFFFF, 1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
